// File: rtl/invader_fleet.sv
// Invader formation state: alive bitmap, formation origin, march/drop timing,
// hit removal and cleared/landed status flags.
module invader_fleet #(
    parameter int unsigned InvadersH  = 11,
    parameter int unsigned InvadersV  = 5,
    parameter int unsigned OffsetH    = 40,
    parameter int unsigned OffsetV    = 32,
    parameter int unsigned SprW       = 32,
    parameter int unsigned SprH       = 24,
    parameter int unsigned StartX     = 100,
    parameter int unsigned StartY     = 60,
    parameter int unsigned StepX      = 4,
    parameter int unsigned DropY      = 16,
    parameter int unsigned LeftBound  = 16,
    parameter int unsigned RightBound = 624,
    parameter int unsigned BottomY    = 420
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           frame_i,
    input  logic                           restart_i,
    input  logic [5:0]                     invader_collision_i,
    output logic [InvadersH*InvadersV-1:0] invaders_o,
    output logic [9:0]                     invaders_x_o,
    output logic [9:0]                     invaders_y_o,
    output logic                           kill_o,
    output logic [5:0]                     alive_cnt_o,
    output logic                           cleared_o,
    output logic                           landed_o
);

    localparam int unsigned NumInv = InvadersH * InvadersV;
    localparam int unsigned ColW   = $clog2(InvadersH);
    localparam int unsigned RowW   = $clog2(InvadersV);

    typedef enum logic [1:0] {StRun, StCleared, StLanded} state_e;

    state_e            state_q, state_d;
    logic [NumInv-1:0] inv_q, inv_d;
    logic [9:0]        x_q, x_d;
    logic [9:0]        y_q, y_d;
    logic              dir_q, dir_d;   // 0 = marching right, 1 = marching left
    logic [5:0]        cnt_q, cnt_d;
    logic              kill_q, kill_d;

    logic [InvadersH-1:0] colmask;
    logic [InvadersV-1:0] rowmask;
    logic [ColW-1:0]      lcol, rcol;
    logic [RowW-1:0]      brow;
    logic                 lfound;
    logic [5:0]           alive_cnt;
    logic [10:0]          left_edge, right_edge, bottom_drop;
    logic [NumInv-1:0]    hit_mask;
    logic                 hit_ok;
    logic                 drop;

    // Formation extents and population from the registered bitmap.
    always_comb begin
        colmask   = '0;
        rowmask   = '0;
        alive_cnt = '0;
        for (int r = 0; r < InvadersV; r++) begin
            for (int c = 0; c < InvadersH; c++) begin
                if (inv_q[r*InvadersH+c]) begin
                    colmask[c] = 1'b1;
                    rowmask[r] = 1'b1;
                end
                alive_cnt = alive_cnt + 6'(inv_q[r*InvadersH+c]);
            end
        end
        lcol   = '0;
        rcol   = '0;
        brow   = '0;
        lfound = 1'b0;
        for (int c = 0; c < InvadersH; c++) begin
            if (colmask[c] && !lfound) begin
                lcol   = ColW'(c);
                lfound = 1'b1;
            end
            if (colmask[c]) rcol = ColW'(c);
        end
        for (int r = 0; r < InvadersV; r++) begin
            if (rowmask[r]) brow = RowW'(r);
        end
        left_edge   = {1'b0, x_q} + 11'(32'(lcol) * OffsetH);
        right_edge  = {1'b0, x_q} + 11'(32'(rcol) * OffsetH) + 11'(SprW);
        // Bottom edge as it would be after a drop this step.
        bottom_drop = {1'b0, y_q} + 11'(DropY) + 11'(32'(brow) * OffsetV) + 11'(SprH);
    end

    // Hit decode: only in-range indices that address a live invader count.
    always_comb begin
        hit_mask = NumInv'(1) << (invader_collision_i - 6'd1);
        hit_ok   = (invader_collision_i != 6'd0) &&
                   (32'(invader_collision_i) <= NumInv) &&
                   (|(inv_q & hit_mask));
    end

    // Next-state: restart reload, hit removal, step timing and march/drop rules.
    always_comb begin
        state_d = state_q;
        inv_d   = inv_q;
        x_d     = x_q;
        y_d     = y_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        kill_d  = 1'b0;
        drop    = 1'b0;
        if (restart_i) begin
            state_d = StRun;
            inv_d   = '1;
            x_d     = 10'(StartX);
            y_d     = 10'(StartY);
            dir_d   = 1'b0;
            cnt_d   = 6'(NumInv);
        end else if (state_q == StRun) begin
            if (hit_ok) begin
                inv_d  = inv_q & ~hit_mask;
                kill_d = 1'b1;
            end
            if (frame_i) begin
                if (cnt_q > 6'd1) begin
                    cnt_d = cnt_q - 6'd1;
                end else begin
                    // Fewer invaders means a shorter step period.
                    cnt_d = (alive_cnt == 6'd0) ? 6'd1 : alive_cnt;
                    if (!dir_q) begin
                        if (right_edge + 11'(StepX) > 11'(RightBound)) drop = 1'b1;
                        else x_d = x_q + 10'(StepX);
                    end else begin
                        if (left_edge < 11'(LeftBound + StepX)) drop = 1'b1;
                        else x_d = x_q - 10'(StepX);
                    end
                    if (drop) begin
                        y_d   = y_q + 10'(DropY);
                        dir_d = ~dir_q;
                        if (bottom_drop >= 11'(BottomY)) state_d = StLanded;
                    end
                end
            end
            if (state_d == StRun && inv_d == '0) state_d = StCleared;
        end
    end

    // All formation state, async active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StRun;
            inv_q   <= '1;
            x_q     <= 10'(StartX);
            y_q     <= 10'(StartY);
            dir_q   <= 1'b0;
            cnt_q   <= 6'(NumInv);
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            inv_q   <= inv_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            kill_q  <= kill_d;
        end
    end

    assign invaders_o   = inv_q;
    assign invaders_x_o = x_q;
    assign invaders_y_o = y_q;
    assign kill_o       = kill_q;
    assign alive_cnt_o  = alive_cnt;
    assign cleared_o    = (state_q == StCleared);
    assign landed_o     = (state_q == StLanded);

endmodule

// File: tb/tb_invader_fleet.sv
// Directed bench for invader_fleet: hit vectors from a table, then hand-computed
// march, edge-drop, clear, land and async-reset sequences.
module tb_invader_fleet;

    logic        clk;
    logic        rst_n;
    logic        frame;
    logic        restart;
    logic [5:0]  coll;
    logic [54:0] invaders;
    logic [9:0]  inv_x;
    logic [9:0]  inv_y;
    logic        kill;
    logic [5:0]  alive_cnt;
    logic        cleared;
    logic        landed;

    int checks   = 0;
    int failures = 0;

    localparam logic [54:0] AllOnes = 55'h7F_FFFF_FFFF_FFFF;

    invader_fleet dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .frame_i             (frame),
        .restart_i           (restart),
        .invader_collision_i (coll),
        .invaders_o          (invaders),
        .invaders_x_o        (inv_x),
        .invaders_y_o        (inv_y),
        .kill_o              (kill),
        .alive_cnt_o         (alive_cnt),
        .cleared_o           (cleared),
        .landed_o            (landed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  coll;
        logic        exp_kill;
        logic [5:0]  exp_alive;
        logic [54:0] exp_inv;
    } hit_vec_t;

    hit_vec_t vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock with the given inputs; outputs sampled 1 time unit after the edge.
    task automatic cyc(input logic f, input logic r, input logic [5:0] c);
        frame   = f;
        restart = r;
        coll    = c;
        @(posedge clk);
        #1;
        frame   = 1'b0;
        restart = 1'b0;
        coll    = 6'd0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 6'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [54:0] col0;
        logic [9:0]  prev_y;
        int          n;

        vecs[0] = '{6'd12, 1'b1, 6'd54, 55'h7F_FFFF_FFFF_F7FF};
        vecs[1] = '{6'd12, 1'b0, 6'd54, 55'h7F_FFFF_FFFF_F7FF};
        vecs[2] = '{6'd12, 1'b0, 6'd54, 55'h7F_FFFF_FFFF_F7FF};
        vecs[3] = '{6'd0,  1'b0, 6'd54, 55'h7F_FFFF_FFFF_F7FF};
        vecs[4] = '{6'd60, 1'b0, 6'd54, 55'h7F_FFFF_FFFF_F7FF};
        vecs[5] = '{6'd56, 1'b0, 6'd54, 55'h7F_FFFF_FFFF_F7FF};
        vecs[6] = '{6'd63, 1'b0, 6'd54, 55'h7F_FFFF_FFFF_F7FF};

        rst_n   = 1'b0;
        frame   = 1'b0;
        restart = 1'b0;
        coll    = 6'd0;
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        check("rst_invaders", 64'(invaders), 64'(AllOnes));
        check("rst_x", 64'(inv_x), 64'd100);
        check("rst_y", 64'(inv_y), 64'd60);
        check("rst_alive", 64'(alive_cnt), 64'd55);
        check("rst_kill", 64'(kill), 64'd0);
        check("rst_cleared", 64'(cleared), 64'd0);
        check("rst_landed", 64'(landed), 64'd0);

        // 54 frames with 55 alive: no step yet
        frames(54);
        check("march_x_54", 64'(inv_x), 64'd100);

        // Hit vectors
        for (int i = 0; i < 7; i++) begin
            cyc(1'b0, 1'b0, vecs[i].coll);
            check($sformatf("hit%0d_kill", i), 64'(kill), 64'(vecs[i].exp_kill));
            check($sformatf("hit%0d_alive", i), 64'(alive_cnt), 64'(vecs[i].exp_alive));
            check($sformatf("hit%0d_inv", i), 64'(invaders), 64'(vecs[i].exp_inv));
            check($sformatf("hit%0d_x", i), 64'(inv_x), 64'd100);
        end

        // 55th frame steps; period reloads to 54
        frames(1);
        check("march_x_55", 64'(inv_x), 64'd104);
        check("march_y_55", 64'(inv_y), 64'd60);
        frames(53);
        check("march_x_53more", 64'(inv_x), 64'd104);
        frames(1);
        check("march_x_54more", 64'(inv_x), 64'd108);

        // Right-edge drop with only column 0 alive
        cyc(1'b0, 1'b1, 6'd0);
        check("rs1_inv", 64'(invaders), 64'(AllOnes));
        check("rs1_x", 64'(inv_x), 64'd100);
        for (int k = 1; k <= 55; k++) begin
            if (((k - 1) % 11) != 0) cyc(1'b0, 1'b0, 6'(k));
        end
        col0 = '0;
        for (int r = 0; r < 5; r++) col0[r*11] = 1'b1;
        check("col0_inv", 64'(invaders), 64'(col0));
        check("col0_alive", 64'(alive_cnt), 64'd5);
        frames(660);
        check("edge_x_588", 64'(inv_x), 64'd588);
        frames(4);
        check("edge_x_hold", 64'(inv_x), 64'd588);
        frames(1);
        check("edge_x_592", 64'(inv_x), 64'd592);
        check("edge_y_60", 64'(inv_y), 64'd60);
        frames(4);
        check("edge_y_hold", 64'(inv_y), 64'd60);
        frames(1);
        check("drop_x", 64'(inv_x), 64'd592);
        check("drop_y", 64'(inv_y), 64'd76);
        frames(5);
        check("left_x", 64'(inv_x), 64'd588);
        check("left_y", 64'(inv_y), 64'd76);

        // Clear the whole fleet, then restart
        cyc(1'b0, 1'b1, 6'd0);
        check("rs2_x", 64'(inv_x), 64'd100);
        for (int k = 1; k <= 54; k++) cyc(1'b0, 1'b0, 6'(k));
        check("clr_pre_cleared", 64'(cleared), 64'd0);
        check("clr_pre_alive", 64'(alive_cnt), 64'd1);
        cyc(1'b0, 1'b0, 6'd55);
        check("clr_kill", 64'(kill), 64'd1);
        check("clr_alive", 64'(alive_cnt), 64'd0);
        check("clr_cleared", 64'(cleared), 64'd1);
        check("clr_landed", 64'(landed), 64'd0);
        frames(60);
        check("clr_x_frozen", 64'(inv_x), 64'd100);
        check("clr_y_frozen", 64'(inv_y), 64'd60);
        check("clr_still", 64'(cleared), 64'd1);
        // Restart with a collision and frame in the same cycle
        cyc(1'b1, 1'b1, 6'd5);
        check("rs3_inv", 64'(invaders), 64'(AllOnes));
        check("rs3_kill", 64'(kill), 64'd0);
        check("rs3_cleared", 64'(cleared), 64'd0);
        check("rs3_x", 64'(inv_x), 64'd100);
        check("rs3_y", 64'(inv_y), 64'd60);
        check("rs3_alive", 64'(alive_cnt), 64'd55);

        // Row 0 only: march until landing at y = 396 (B = 420)
        for (int k = 12; k <= 55; k++) cyc(1'b0, 1'b0, 6'(k));
        check("row0_inv", 64'(invaders), 64'h7FF);
        check("row0_alive", 64'(alive_cnt), 64'd11);
        for (int j = 1; j <= 21; j++) begin
            prev_y = inv_y;
            n      = 0;
            while (inv_y == prev_y && n < 2000) begin
                cyc(1'b1, 1'b0, 6'd0);
                n++;
            end
            check($sformatf("drop%0d_in_budget", j), 64'(n < 2000), 64'd1);
            if (n >= 2000) break;
            check($sformatf("drop%0d_y", j), 64'(inv_y), 64'(60 + 16 * j));
            check($sformatf("drop%0d_x", j), 64'(inv_x), (j % 2 == 1) ? 64'd192 : 64'd16);
            check($sformatf("drop%0d_landed", j), 64'(landed), 64'(j == 21));
        end
        frames(30);
        check("land_x_frozen", 64'(inv_x), 64'd192);
        check("land_y_frozen", 64'(inv_y), 64'd396);
        check("land_cleared", 64'(cleared), 64'd0);
        cyc(1'b0, 1'b0, 6'd1);
        check("land_hit_kill", 64'(kill), 64'd0);
        check("land_hit_inv", 64'(invaders), 64'h7FF);

        // Asynchronous reset between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_inv", 64'(invaders), 64'(AllOnes));
        check("arst_x", 64'(inv_x), 64'd100);
        check("arst_y", 64'(inv_y), 64'd60);
        check("arst_landed", 64'(landed), 64'd0);
        check("arst_alive", 64'(alive_cnt), 64'd55);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("arst_rel_landed", 64'(landed), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
